// File: rtl/wb_int_ctrl_if.sv
// Wishbone slave-slot bundle for wb_int_ctrl: strobe, write enable,
// word address, write/read data and the acknowledge pulse.
// The master modport is the intercon/bench side; the slave modport is the controller.
interface wb_int_ctrl_if;
  logic        STB;
  logic        WE;
  logic [1:0]  ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;

  modport master (
    output STB,
    output WE,
    output ADDR,
    output DAT_I,
    input  DAT_O,
    input  ACK
  );

  modport slave (
    input  STB,
    input  WE,
    input  ADDR,
    input  DAT_I,
    output DAT_O,
    output ACK
  );
endinterface

// File: rtl/wb_int_ctrl.sv
// wb_int_ctrl: Wishbone-slave interrupt controller.
// Latches N_SRC sources into PENDING (per-source level or rising-edge mode),
// gates them with MASK and drives a registered INT plus the CAUSE index of the
// lowest-numbered active source (source 0 has the highest priority).
// Register map (word address): 0 PENDING (W1C), 1 MASK, 2 EDGE, 3 STATUS (RO).
// Optional build macro WB_INT_CTRL_SYNC_EN inserts a 2-flop synchronizer on src
// for asynchronous sources (src->INT latency grows from 2 to 4 cycles).
module wb_int_ctrl #(
  parameter int          N_SRC    = 6,
  parameter int          CAUSE_W  = 32,
  parameter logic [31:0] MASK_RST = 32'hFFFF_FFFF,
  parameter logic [31:0] EDGE_RST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               RSTN,
  input  logic [N_SRC-1:0]   src,
  wb_int_ctrl_if.slave       bus,
  output logic               INT,
  output logic [CAUSE_W-1:0] CAUSE
);

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] lowest_set(input logic [N_SRC-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [N_SRC-1:0] s_s;
  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] edge_r;
  logic             ack_r;
  logic [31:0]      dat_o_r;
  logic             int_r;
  logic [4:0]       cause_r;

  logic             wr_commit_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] pend_nxt_s;
  logic [N_SRC-1:0] act_s;
  logic [31:0]      rd_data_s;
  logic             unused_dat_s;

`ifdef WB_INT_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1_r;
  logic [N_SRC-1:0] sync2_r;

  // Two-flop synchronizer for sources that are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      sync1_r <= {N_SRC{1'b0}};
      sync2_r <= {N_SRC{1'b0}};
    end else begin
      sync1_r <= src;
      sync2_r <= sync1_r;
    end
  end

  assign s_s = sync2_r;
`else
  assign s_s = src;
`endif

  // Upper write-data bits have no storage behind them.
  assign unused_dat_s = ^bus.DAT_I[31:N_SRC];

  // Bus decode, pending next-state, priority inputs and read mux.
  always_comb begin
    wr_commit_s = 1'b0;
    w1c_s       = {N_SRC{1'b0}};
    pend_nxt_s  = pending_r;
    act_s       = pending_r & mask_r;
    rd_data_s   = 32'd0;

    // A write commits on the edge that ends the ACK cycle.
    if (ack_r && bus.STB && bus.WE) begin
      wr_commit_s = 1'b1;
    end else begin
      wr_commit_s = 1'b0;
    end

    if (wr_commit_s && (bus.ADDR == 2'd0)) begin
      w1c_s = bus.DAT_I[N_SRC-1:0];
    end else begin
      w1c_s = {N_SRC{1'b0}};
    end

    // Edge bits: a new rising edge beats a simultaneous clear.
    // Level bits: simply follow the source, so W1C has no lasting effect.
    pend_nxt_s = (edge_r & ((s_s & ~src_q_r) | (pending_r & ~w1c_s)))
               | (~edge_r & s_s);

    case (bus.ADDR)
      2'd0:    rd_data_s = 32'(pending_r);
      2'd1:    rd_data_s = 32'(mask_r);
      2'd2:    rd_data_s = 32'(edge_r);
      2'd3:    rd_data_s = {int_r, 26'd0, cause_r};
      default: rd_data_s = 32'd0;
    endcase
  end

  // Source history, pending latch and the MASK/EDGE registers.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      src_q_r   <= {N_SRC{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= MASK_RST[N_SRC-1:0];
      edge_r    <= EDGE_RST[N_SRC-1:0];
    end else begin
      src_q_r   <= s_s;
      pending_r <= pend_nxt_s;
      if (wr_commit_s && (bus.ADDR == 2'd1)) begin
        mask_r <= bus.DAT_I[N_SRC-1:0];
      end
      if (wr_commit_s && (bus.ADDR == 2'd2)) begin
        edge_r <= bus.DAT_I[N_SRC-1:0];
      end
    end
  end

  // Wishbone acknowledge pulse and read-data capture (DAT_O holds when idle).
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      ack_r   <= 1'b0;
      dat_o_r <= 32'd0;
    end else begin
      ack_r <= bus.STB & ~ack_r;
      if (bus.STB && !ack_r) begin
        dat_o_r <= rd_data_s;
      end
    end
  end

  // Registered interrupt request and cause index, always updated together.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      int_r   <= 1'b0;
      cause_r <= 5'd0;
    end else begin
      int_r   <= |act_s;
      cause_r <= lowest_set(act_s);
    end
  end

  assign bus.ACK   = ack_r;
  assign bus.DAT_O = dat_o_r;
  assign INT       = int_r;
  assign CAUSE     = CAUSE_W'(cause_r);

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Directed self-checking bench for wb_int_ctrl (default build, 6 sources,
// MASK reset 6'h20, EDGE reset 0). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_wb_int_ctrl;
  logic        clk;
  logic        rstn;
  logic [5:0]  src;
  logic        irq;
  logic [31:0] cause;
  logic [31:0] rd;
  int          checks;
  int          errors;

  wb_int_ctrl_if bus ();

  wb_int_ctrl #(
    .N_SRC    (6),
    .CAUSE_W  (32),
    .MASK_RST (32'h0000_0020),
    .EDGE_RST (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .RSTN  (rstn),
    .src   (src),
    .bus   (bus),
    .INT   (irq),
    .CAUSE (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = a; bus.DAT_I = d;
    tick();
    check_eq("wr_ack", 32'(bus.ACK), 32'd1);
    tick();
    bus.STB = 1'b0; bus.WE = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    bus.STB = 1'b1; bus.WE = 1'b0; bus.ADDR = a;
    tick();
    d = bus.DAT_O;
    tick();
    bus.STB = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; src = 6'h20;
    bus.STB = 1'b0; bus.WE = 1'b0; bus.ADDR = 2'd0; bus.DAT_I = 32'd0;

    // Reset state, source 5 already high
    repeat (3) tick();
    check_eq("rst_int", 32'(irq), 32'd0);
    check_eq("rst_cause", cause, 32'd0);
    check_eq("rst_ack", 32'(bus.ACK), 32'd0);
    check_eq("rst_dato", bus.DAT_O, 32'd0);
    rstn = 1'b1;
    tick();
    check_eq("rel_int_k", 32'(irq), 32'd0);
    tick();
    check_eq("rel_int", 32'(irq), 32'd1);
    check_eq("rel_cause", cause, 32'd5);
    wb_read(2'd3, rd); check_eq("status", rd, 32'h8000_0005);
    wb_read(2'd1, rd); check_eq("mask_rst", rd, 32'h20);
    wb_read(2'd2, rd); check_eq("edge_rst", rd, 32'h0);

    // Level mode priority
    src = 6'b001010;
    wb_write(2'd1, 32'h3F);
    tick();
    check_eq("lvl_int", 32'(irq), 32'd1);
    check_eq("lvl_cause1", cause, 32'd1);
    src = 6'b001000;
    tick();
    check_eq("lvl_cause_lag", cause, 32'd1);
    tick();
    check_eq("lvl_cause3", cause, 32'd3);
    src = 6'b000000;
    tick(); tick();
    check_eq("lvl_int_off", 32'(irq), 32'd0);
    check_eq("lvl_cause0", cause, 32'd0);
    src = 6'b000001;
    tick(); tick();
    wb_write(2'd0, 32'h1);
    wb_read(2'd0, rd); check_eq("lvl_w1c", rd, 32'h1);
    src = 6'b000000;
    tick(); tick();

    // Edge mode latch and W1C
    wb_write(2'd2, 32'h3F);
    wb_read(2'd2, rd); check_eq("edge_rd", rd, 32'h3F);
    src = 6'b000100; tick();
    src = 6'b000000; tick();
    check_eq("edg_int", 32'(irq), 32'd1);
    check_eq("edg_cause", cause, 32'd2);
    tick(); tick();
    check_eq("edg_hold", 32'(irq), 32'd1);
    wb_read(2'd0, rd); check_eq("edg_pend", rd, 32'h04);
    wb_write(2'd0, 32'h4);
    check_eq("w1c_int_lag", 32'(irq), 32'd1);
    tick();
    check_eq("w1c_int_off", 32'(irq), 32'd0);

    // Rising edge in the same cycle as W1C commit: set wins
    src = 6'b000001; tick();
    src = 6'b000000; tick(); tick();
    check_eq("race_pre", 32'(irq), 32'd1);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 2'd0; bus.DAT_I = 32'h1;
    tick();
    src = 6'b000001;
    tick();
    bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    check_eq("race_int", 32'(irq), 32'd1);
    check_eq("race_cause", cause, 32'd0);
    wb_read(2'd0, rd); check_eq("race_pend", rd, 32'h01);
    src = 6'b000000; tick();

    // Masking
    src = 6'h3F; tick();
    src = 6'h00; tick();
    wb_write(2'd1, 32'h0);
    tick();
    check_eq("mask0_int", 32'(irq), 32'd0);
    check_eq("mask0_cause", cause, 32'd0);
    wb_read(2'd0, rd); check_eq("mask0_pend", rd, 32'h3F);
    wb_write(2'd1, 32'h10);
    tick();
    check_eq("mask10_int", 32'(irq), 32'd1);
    check_eq("mask10_cause", cause, 32'd4);

    // STB held: ACK every second cycle, then reset during ACK
    bus.STB = 1'b1; bus.WE = 1'b0; bus.ADDR = 2'd1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq($sformatf("hold_ack%0d", i), 32'(bus.ACK), 32'(i % 2));
      if (i % 2 == 1) check_eq($sformatf("hold_dat%0d", i), bus.DAT_O, 32'h10);
    end
    rstn = 1'b0;
    tick();
    check_eq("mid_rst_ack", 32'(bus.ACK), 32'd0);
    check_eq("mid_rst_dato", bus.DAT_O, 32'd0);
    check_eq("mid_rst_int", 32'(irq), 32'd0);
    bus.STB = 1'b0;
    rstn = 1'b1;
    tick();

    // Write interrupted by reset is discarded
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 2'd1; bus.DAT_I = 32'h3F;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1; bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    wb_read(2'd1, rd); check_eq("rst_discard", rd, 32'h20);
    tick(); tick();
    check_eq("dato_hold", bus.DAT_O, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
